// File: rtl/fpu_cvt_arb.sv
// fpu_cvt_arb: lets two requesters share one external FP64->FP32 narrowing converter.
//   Requester A is FPU execute (FCNVDS). Requester B is the FP store path.
//   Arbitration is round-robin, or fixed priority to A with a starvation guard for B.
//   Pipeline: the S1 operand register drives cvt_src. The S2 result register captures
//   cvt_dst and drives rsp_*. Both ends use a valid/ready handshake.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   a_valid/a_ready       requester A handshake (a_ready is combinational: grant this cycle)
//   a_src, a_tag          requester A FP64 operand and tag
//   b_valid/b_ready       requester B handshake (b_ready is combinational: grant this cycle)
//   b_src, b_tag          requester B FP64 operand and tag
//   cvt_src               operand to the external converter, straight from S1
//   cvt_dst               converter result, combinational from cvt_src
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                0 = A, 1 = B
//   rsp_tag, rsp_data     tag of the granted request and FP32 result
//   busy                  either pipeline stage holds a valid entry
module fpu_cvt_arb #(
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned FIXED_PRI  = 0,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [63:0]      a_src,
    input  logic [TAG_W-1:0] a_tag,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [63:0]      b_src,
    input  logic [TAG_W-1:0] b_tag,
    output logic [63:0]      cvt_src,
    input  logic [31:0]      cvt_dst,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_data,
    output logic             busy
);

    localparam int unsigned CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    // Stage 1 state. Its operand is the cvt_src register itself.
    logic             s1_v;
    logic             s1_id;
    logic [TAG_W-1:0] s1_tag;

    // Arbitration state
    logic             rr_ptr;       // 0 = A preferred, 1 = B preferred
    logic [CNT_W-1:0] starve_cnt;

    // Combinational control
    logic adv1;
    logic adv2;
    logic starved;
    logic pick_b;
    logic take;

    // Pipeline advance, arbitration and grant generation
    always_comb begin
        adv2    = !rsp_valid || rsp_ready;
        adv1    = !s1_v || adv2;
        starved = (starve_cnt == CNT_W'(STARVE_LIM));
        pick_b  = 1'b0;
        if (FIXED_PRI != 0) begin
            pick_b = b_valid && (!a_valid || starved);
        end else begin
            pick_b = b_valid && (!a_valid || rr_ptr);
        end
        // No grant can be issued while reset is held low.
        take    = reset && adv1 && (a_valid || b_valid);
        a_ready = take && !pick_b;
        b_ready = take && pick_b;
    end

    // Stage 1: capture the granted operand
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v    <= 1'b0;
            s1_id   <= 1'b0;
            s1_tag  <= '0;
            cvt_src <= '0;
        end else if (adv1) begin
            s1_v <= take;
            if (take) begin
                s1_id   <= pick_b;
                s1_tag  <= pick_b ? b_tag : a_tag;
                cvt_src <= pick_b ? b_src : a_src;
            end
        end
    end

    // Stage 2: capture the converter output. It holds while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_tag   <= '0;
            rsp_data  <= '0;
        end else if (adv2) begin
            rsp_valid <= s1_v;
            if (s1_v) begin
                rsp_id   <= s1_id;
                rsp_tag  <= s1_tag;
                rsp_data <= cvt_dst;
            end
        end
    end

    // Round-robin pointer: it points away from the side that was just served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
        end else if (take) begin
            rr_ptr <= !pick_b;
        end
    end

    // Count the cycles in which B is waiting and loses to A.
    // The count clears once B is served or withdraws, and saturates at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if ((FIXED_PRI != 0) && adv1) begin
            if (!b_valid || b_ready) begin
                starve_cnt <= '0;
            end else if (a_ready && !starved) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    assign busy = s1_v || rsp_valid;

endmodule
